// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue stage: MIPS opcode values, field positions
// and the writeback-destination decode that both the issue logic and the ALU use.
package alu_issue_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  typedef struct packed {
    logic       en;
    logic [4:0] addr;
  } wb_t;

  // Destination register of an instruction; r0 targets are reported as no-write.
  function automatic wb_t wb_dest(input logic [31:0] inst);
    wb_t w;
    w.en   = 1'b0;
    w.addr = 5'd0;
    case (inst[OP_MSB:OP_LSB])
      OP_RTYPE: begin
        w.en   = 1'b1;
        w.addr = inst[RD_MSB:RD_LSB];
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        w.en   = 1'b1;
        w.addr = inst[RT_MSB:RT_LSB];
      end
      default: begin
        w.en   = 1'b0;
        w.addr = 5'd0;
      end
    endcase
    w.en = w.en & (w.addr != 5'd0);
    return w;
  endfunction

endpackage

// File: rtl/alu_issue_fifo.sv
// Synchronous FIFO with power-of-two depth; pointers carry one extra wrap bit
// so full and empty are distinguished without a separate occupancy counter.
module alu_issue_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign dout      = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage; contents are qualified by the pointers so they need no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= din;
  end

endmodule

// File: rtl/alu_issue.sv
// Instruction queue, register file and issue register feeding an external ALU;
// results are written back when the ALU accepts the issued instruction.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int RF_INIT_ZERO = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_inst,
  output logic        in_ready,
  output logic        issue_valid,
  output logic [31:0] issue_inst,
  output logic [31:0] issue_reg_a,
  output logic [31:0] issue_reg_b,
  input  logic        issue_ready,
  input  logic [31:0] alu_res,
  input  logic [2:0]  alu_flag,
  output logic [2:0]  last_flag,
  output logic [15:0] retire_count
);

  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic [31:0] fifo_head_s;
  logic        push_s;
  logic        fire_s;
  logic        load_s;
  wb_t         wb_s;
  logic        wb_en_s;
  logic [4:0]  rs_s;
  logic [4:0]  rt_s;
  logic [31:0] op_a_s;
  logic [31:0] op_b_s;

  logic [31:0] rf_r [32];
  logic        issue_valid_r;
  logic [31:0] issue_inst_r;
  logic [31:0] issue_reg_a_r;
  logic [31:0] issue_reg_b_r;
  logic [2:0]  last_flag_r;
  logic [15:0] retire_count_r;

  assign in_ready     = ~fifo_full_s;
  assign push_s       = in_valid & ~fifo_full_s;
  assign fire_s       = issue_valid_r & issue_ready;
  assign load_s       = (~issue_valid_r | fire_s) & ~fifo_empty_s;
  assign wb_s         = wb_dest(issue_inst_r);
  assign wb_en_s      = fire_s & wb_s.en;
  assign rs_s         = fifo_head_s[RS_MSB:RS_LSB];
  assign rt_s         = fifo_head_s[RT_MSB:RT_LSB];

  assign issue_valid  = issue_valid_r;
  assign issue_inst   = issue_inst_r;
  assign issue_reg_a  = issue_reg_a_r;
  assign issue_reg_b  = issue_reg_b_r;
  assign last_flag    = last_flag_r;
  assign retire_count = retire_count_r;

  alu_issue_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .din   (in_inst),
    .pop   (load_s),
    .dout  (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Operand read with bypass: a result retiring this cycle overrides the stale file entry.
  always_comb begin
    op_a_s = 32'd0;
    op_b_s = 32'd0;
    if (rs_s == 5'd0) begin
      op_a_s = 32'd0;
    end else if (wb_en_s && (rs_s == wb_s.addr)) begin
      op_a_s = alu_res;
    end else begin
      op_a_s = rf_r[rs_s];
    end
    if (rt_s == 5'd0) begin
      op_b_s = 32'd0;
    end else if (wb_en_s && (rt_s == wb_s.addr)) begin
      op_b_s = alu_res;
    end else begin
      op_b_s = rf_r[rt_s];
    end
  end

  generate
    if (RF_INIT_ZERO != 0) begin : g_rf_rst
      // Register file, cleared on reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < 32; i++) rf_r[i] <= 32'd0;
        end else if (wb_en_s) begin
          rf_r[wb_s.addr] <= alu_res;
        end
      end
    end else begin : g_rf_norst
      // Register file without reset; r0 is never written and always reads as zero.
      always_ff @(posedge clk) begin
        if (wb_en_s) rf_r[wb_s.addr] <= alu_res;
      end
    end
  endgenerate

  // Issue register: refill from the queue head whenever the slot is free or retiring.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid_r <= 1'b0;
      issue_inst_r  <= 32'd0;
      issue_reg_a_r <= 32'd0;
      issue_reg_b_r <= 32'd0;
    end else if (load_s) begin
      issue_valid_r <= 1'b1;
      issue_inst_r  <= fifo_head_s;
      issue_reg_a_r <= op_a_s;
      issue_reg_b_r <= op_b_s;
    end else if (fire_s) begin
      issue_valid_r <= 1'b0;
    end
  end

  // Retirement status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_flag_r    <= 3'd0;
      retire_count_r <= 16'd0;
    end else if (fire_s) begin
      last_flag_r    <= alu_flag;
      retire_count_r <= retire_count_r + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: a small ALU model answers the issued instruction,
// and register contents are observed by issuing non-writing probe instructions.
module tb_alu_issue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_inst;
  logic        in_ready;
  logic        issue_valid;
  logic [31:0] issue_inst;
  logic [31:0] issue_reg_a;
  logic [31:0] issue_reg_b;
  logic        issue_ready;
  logic [31:0] alu_res;
  logic [2:0]  alu_flag;
  logic [2:0]  last_flag;
  logic [15:0] retire_count;

  logic        ovr_en;
  logic [31:0] ovr_val;
  logic [2:0]  flag_drv;
  int          total;
  int          bad;
  int          exp_rc;

  alu_issue #(.FIFO_DEPTH(4), .RF_INIT_ZERO(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_inst      (in_inst),
    .in_ready     (in_ready),
    .issue_valid  (issue_valid),
    .issue_inst   (issue_inst),
    .issue_reg_a  (issue_reg_a),
    .issue_reg_b  (issue_reg_b),
    .issue_ready  (issue_ready),
    .alu_res      (alu_res),
    .alu_flag     (alu_flag),
    .last_flag    (last_flag),
    .retire_count (retire_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ALU model: R-type adds a+b, everything else adds a + sign-extended immediate.
  always_comb begin
    if (ovr_en) alu_res = ovr_val;
    else if (issue_inst[31:26] == 6'h00) alu_res = issue_reg_a + issue_reg_b;
    else alu_res = issue_reg_a + {{16{issue_inst[15]}}, issue_inst[15:0]};
  end
  assign alu_flag = flag_drv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [31:0] inst);
    in_valid = 1'b1;
    in_inst  = inst;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_issue(input string tag);
    int n;
    n = 0;
    while (!issue_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_wait"}, 32'(issue_valid), 32'd1);
  endtask

  task automatic run_one(input string tag, input logic [31:0] inst,
                         output logic [31:0] a, output logic [31:0] b);
    push1(inst);
    wait_issue(tag);
    a = issue_reg_a;
    b = issue_reg_b;
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    exp_rc++;
  endtask

  task automatic probe(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [31:0] ea, input logic [31:0] eb);
    logic [31:0] a;
    logic [31:0] b;
    run_one(tag, {6'h04, rs, rt, 16'h0000}, a, b);
    chk({tag, "_a"}, a, ea);
    chk({tag, "_b"}, b, eb);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_valid"}, 32'(issue_valid), 32'd0);
    chk({tag, "_inst"}, issue_inst, 32'd0);
    chk({tag, "_reg_a"}, issue_reg_a, 32'd0);
    chk({tag, "_reg_b"}, issue_reg_b, 32'd0);
    chk({tag, "_flag"}, 32'(last_flag), 32'd0);
    chk({tag, "_rc"}, 32'(retire_count), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    issue_ready = 1'b0;
    step();
    step();
    chk_reset(tag);
    rst_n  = 1'b1;
    exp_rc = 0;
    step();
  endtask

  // Two instructions pushed back to back with the ALU always ready; returns state at B's load.
  task automatic b2b(input logic [31:0] ia, input logic [31:0] ib,
                     output logic [31:0] inst_b, output logic [31:0] ra, output logic [31:0] rb);
    issue_ready = 1'b1;
    in_valid    = 1'b1;
    in_inst     = ia;
    step();
    in_inst = ib;
    step();
    in_valid = 1'b0;
    step();
    inst_b = issue_inst;
    ra     = issue_reg_a;
    rb     = issue_reg_b;
    step();
    issue_ready = 1'b0;
    exp_rc += 2;
  endtask

  logic [31:0] a_v;
  logic [31:0] b_v;
  logic [31:0] i_v;
  logic [31:0] seq [5];

  initial begin
    total       = 0;
    bad         = 0;
    exp_rc      = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_inst     = 32'd0;
    issue_ready = 1'b0;
    ovr_en      = 1'b0;
    ovr_val     = 32'd0;
    flag_drv    = 3'd0;

    // addi r1,r0,5: latency, operand, retirement
    do_reset("rst0");
    push1(32'h20010005);
    chk("lat_early", 32'(issue_valid), 32'd0);
    step();
    chk("lat_valid", 32'(issue_valid), 32'd1);
    chk("addi_inst", issue_inst, 32'h20010005);
    chk("addi_a", issue_reg_a, 32'd0);
    flag_drv    = 3'b010;
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    exp_rc++;
    chk("addi_rc", 32'(retire_count), 32'(exp_rc));
    chk("addi_flag", 32'(last_flag), 32'd2);
    chk("addi_idle", 32'(issue_valid), 32'd0);
    probe("p_r1", 5'd1, 5'd0, 32'd5, 32'd0);

    // Bypass: add r2,r1,r1 loaded while addi r1 retires
    do_reset("rst1");
    b2b(32'h20010005, 32'h00211020, i_v, a_v, b_v);
    chk("byp_inst", i_v, 32'h00211020);
    chk("byp_a", a_v, 32'd5);
    chk("byp_b", b_v, 32'd5);
    chk("byp_rc", 32'(retire_count), 32'(exp_rc));
    probe("p_r2", 5'd2, 5'd1, 32'd10, 32'd5);

    // Fill: 1 in issue register + 4 queued, then full-queue push/pop collision
    for (int k = 0; k < 5; k++) begin
      seq[k] = {6'h08, 5'd0, 5'(3 + k), 16'(11 + k)};
      push1(seq[k]);
    end
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_inst", issue_inst, seq[0]);
    in_valid = 1'b1;
    in_inst  = 32'h2009_0063;
    step();
    step();
    chk("hold_ready", 32'(in_ready), 32'd0);
    chk("hold_inst", issue_inst, seq[0]);
    chk("hold_valid", 32'(issue_valid), 32'd1);
    issue_ready = 1'b1;
    chk("order0", issue_inst, seq[0]);
    step();
    in_valid = 1'b0;
    chk("pop_ready", 32'(in_ready), 32'd1);
    for (int k = 1; k < 5; k++) begin
      chk("order", issue_inst, seq[k]);
      step();
    end
    issue_ready = 1'b0;
    exp_rc += 5;
    chk("drain_idle", 32'(issue_valid), 32'd0);
    chk("drain_rc", 32'(retire_count), 32'(exp_rc));
    probe("p_r34", 5'd3, 5'd4, 32'd11, 32'd12);
    probe("p_r56", 5'd5, 5'd6, 32'd13, 32'd14);
    probe("p_r7", 5'd7, 5'd0, 32'd15, 32'd0);

    // Non-writing opcodes with a poison result
    ovr_en   = 1'b1;
    ovr_val  = 32'hDEADBEEF;
    flag_drv = 3'b101;
    run_one("beq", 32'h10000008, a_v, b_v);
    chk("beq_flag", 32'(last_flag), 32'd5);
    flag_drv = 3'b110;
    run_one("sw", 32'hAC000000, a_v, b_v);
    chk("sw_flag", 32'(last_flag), 32'd6);
    flag_drv = 3'b011;
    run_one("beq_rd", {6'h04, 5'd3, 5'd4, 16'h1800}, a_v, b_v);
    run_one("sw_rt", 32'hAC050000, a_v, b_v);
    run_one("lw_rt", 32'h8C060000, a_v, b_v);
    run_one("bne_rt", {6'h05, 5'd0, 5'd7, 16'h0000}, a_v, b_v);
    chk("nw_flag", 32'(last_flag), 32'd3);
    ovr_en   = 1'b0;
    flag_drv = 3'd0;
    probe("nw_r34", 5'd3, 5'd4, 32'd11, 32'd12);
    probe("nw_r56", 5'd5, 5'd6, 32'd13, 32'd14);
    probe("nw_r7", 5'd7, 5'd0, 32'd15, 32'd0);
    chk("nw_rc", 32'(retire_count), 32'(exp_rc));

    // r0 is hardwired: neither the file nor the bypass may return the write
    run_one("r0w", 32'h20000007, a_v, b_v);
    probe("p_r0", 5'd0, 5'd0, 32'd0, 32'd0);
    b2b(32'h20000007, 32'h10000000, i_v, a_v, b_v);
    chk("r0byp_inst", i_v, 32'h10000000);
    chk("r0byp_a", a_v, 32'd0);
    chk("r0byp_b", b_v, 32'd0);

    // Mid-operation reset with 3 queued and one issued
    for (int k = 0; k < 4; k++) push1({6'h08, 5'd0, 5'(1 + k), 16'h0077});
    chk("pre_rst_valid", 32'(issue_valid), 32'd1);
    #2;
    rst_n       = 1'b0;
    issue_ready = 1'b1;
    #1;
    chk_reset("rst_mid");
    step();
    chk("rst_hold_rc", 32'(retire_count), 32'd0);
    rst_n       = 1'b1;
    issue_ready = 1'b0;
    exp_rc      = 0;
    step();
    step();
    chk("post_rst_valid", 32'(issue_valid), 32'd0);
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    probe("p_zero12", 5'd1, 5'd2, 32'd0, 32'd0);
    probe("p_zero34", 5'd3, 5'd4, 32'd0, 32'd0);
    chk("post_rst_rc", 32'(retire_count), 32'(exp_rc));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, instruction queue entries (power of two, >=2).
REQ-002 Parameter RF_INIT_ZERO, default 1, register file cleared on reset when 1.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream instruction valid.
REQ-006 in_inst  input  32  MIPS-format instruction word.
REQ-007 in_ready  output  1  queue can accept; equals !full, independent of same-cycle pop.
REQ-008 issue_valid  output  1  issue register holds an instruction for the ALU.
REQ-009 issue_inst  output  32  instruction presented to the ALU (instSet).
REQ-010 issue_reg_a  output  32  operand A, value of register rs = inst[25:21].
REQ-011 issue_reg_b  output  32  operand B, value of register rt = inst[20:16].
REQ-012 issue_ready  input  1  ALU side accepts; alu_res/alu_flag valid in the same cycle.
REQ-013 alu_res  input  32  combinational ALU result for issue_inst.
REQ-014 alu_flag  input  3  combinational ALU flag for issue_inst.
REQ-015 last_flag  output  3  alu_flag captured at the most recent fire.
REQ-016 retire_count  output  16  number of fired instructions, wraps at 0xFFFF->0.

Function
REQ-017 Push when in_valid && in_ready; FIFO order strictly preserved; no drop, no duplicate.
REQ-018 Fire when issue_valid && issue_ready; issue outputs held stable while issue_valid && !issue_ready.
REQ-019 Issue register loads FIFO head at an edge where (!issue_valid || fire) and FIFO non-empty; else issue_valid clears on fire.
REQ-020 Queue-to-issue latency: an instruction pushed into an empty queue with empty issue register appears on issue_valid one cycle after the push edge.
REQ-021 Operands are read from the 32x32 register file at load time; r0 reads 0 always.
REQ-022 Writeback on fire: opcode 0x00 (R-type) writes alu_res to rd = inst[15:11]; opcodes 0x08,0x09,0x0A,0x0B,0x0C,0x0D,0x0E write rt.
REQ-023 No writeback for beq (0x04), bne (0x05), lw (0x23), sw (0x2B), or any other opcode; writes to r0 suppressed.
REQ-024 Bypass: when load coincides with a writing fire, a source register equal to the write destination (non-zero) takes alu_res, not the stale file value.
REQ-025 Simultaneous push and pop on a full queue: push refused (in_ready low), pop proceeds.
REQ-026 Pointers use FIFO_DEPTH wrap-around with an extra bit for full/empty disambiguation.
REQ-027 last_flag and retire_count update only on fire.

Reset
REQ-028 rst_n low: FIFO empty, in_ready 1, issue_valid 0, issue_inst/reg_a/reg_b 0, last_flag 0, retire_count 0, register file 0 (RF_INIT_ZERO=1).
REQ-029 Reset asserted mid-operation discards queued and issued instructions; no writeback occurs at or after the reset edge.

Structure
REQ-030 Shared package holds opcode constants (OP_RTYPE, OP_ADDI .. OP_SW) and field position constants, reused by the ALU.
REQ-031 One sub-module, alu_issue_fifo (parameterized sync FIFO); register file and issue register inline.

Verification
REQ-032 Reset then push addi r1,r0,5 (0x20010005), bench ALU returns reg_a+imm: issue_reg_a=0 next cycle, after fire r1=5, retire_count=1.
REQ-033 Back-to-back 0x20010005 then add r2,r1,r1 (0x00211020), issue_ready=1: second issue shows reg_a=reg_b=5 via bypass, r2=10.
REQ-034 Push 5 instructions with issue_ready=0, FIFO_DEPTH=4: 1 in issue reg, 4 queued, in_ready=0, outputs stable; release -> all retire in order.
REQ-035 beq 0x10000008 and sw 0xAC000000 fired with alu_res=0xDEADBEEF: no register changes, last_flag = driven alu_flag.
REQ-036 Write to r0 via addi r0,r0,7 (0x20000007): subsequent reads of r0 return 0.
REQ-037 rst_n pulsed low with 3 queued: all outputs at reset values, later instructions issue with zero-file operands.
